// File: rtl/harp_pkg.sv
// Shared types and constants for the harp voice allocator.
package harp_pkg;

  localparam int unsigned NUM_BEAMS = 8;
  localparam int unsigned NOTE_W    = 3;
  // Widest voice index (pool of up to 8 voices); narrowed at the top level.
  localparam int unsigned VOICE_W   = 3;

  typedef enum logic [1:0] {
    SCAN,
    EMIT,
    DRAIN
  } harp_state_e;

  typedef struct packed {
    logic               on;
    logic [VOICE_W-1:0] voice;
    logic [NOTE_W-1:0]  note;
  } harp_event_t;

endpackage

// File: rtl/harp_debounce.sv
// Two-flop synchronizer plus stability counter; the level flips after DEBOUNCE_CYCLES
// consecutive samples of the opposite value, with a one-cycle flip strobe alongside.
module harp_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic flip
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             flip_q, flip_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    flip_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        flip_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      flip_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      level_q <= level_d;
      flip_q  <= flip_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign flip  = flip_q;

endmodule

// File: rtl/harp_voice_allocator.sv
// Round-robin beam scheduler assigning synth voices and reporting note events.
// Define HARP_VOICE_STEAL_EN to steal the oldest voice instead of dropping a press.
module harp_voice_allocator
  import harp_pkg::*;
#(
  parameter int unsigned NUM_VOICES      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  localparam int unsigned VIDX_W         = $clog2(NUM_VOICES)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_BEAMS-1:0]         beam,
  input  logic                         pedal,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [4+VIDX_W-1:0]          evt_data,
  output logic [15:0]                  drop_count
);

  localparam logic [VIDX_W-1:0] AGE_MAX  = VIDX_W'(NUM_VOICES - 1);
  localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(NUM_VOICES - 1);

  logic [NUM_BEAMS-1:0] beam_lvl, beam_flip;
  logic                 pedal_lvl, pedal_flip;

  for (genvar b = 0; b < NUM_BEAMS; b++) begin : g_beam_db
    harp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_beam_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (beam[b]),
      .level  (beam_lvl[b]),
      .flip   (beam_flip[b])
    );
  end

  harp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pedal_db (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (pedal),
    .level  (pedal_lvl),
    .flip   (pedal_flip)
  );

  harp_state_e          state_q, state_d;
  logic [NOTE_W-1:0]    p_q, p_d;
  logic [NUM_BEAMS-1:0] pend_q, pend_d, ptype_q, ptype_d;
  logic                 pedal_up_q, pedal_up_d;
  logic [VIDX_W-1:0]    drain_q, drain_d;
  logic [NUM_VOICES-1:0] act_q, act_d, sus_q, sus_d;
  logic [NOTE_W-1:0]    note_q [NUM_VOICES];
  logic [NOTE_W-1:0]    note_d [NUM_VOICES];
  logic [VIDX_W-1:0]    age_q  [NUM_VOICES];
  logic [VIDX_W-1:0]    age_d  [NUM_VOICES];
  harp_event_t          evt_q, evt_d;
  logic [15:0]          drop_q, drop_d;

  logic                 hold_found, free_found, rel_found, alloc_en;
  logic [VIDX_W-1:0]    hold_idx, free_idx, rel_idx, alloc_idx;

  // Lowest-index matches for the beam under the scan pointer.
  always_comb begin
    hold_found = 1'b0;
    hold_idx   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    rel_found  = 1'b0;
    rel_idx    = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!hold_found && act_q[v] && sus_q[v] && note_q[v] == p_q) begin
        hold_found = 1'b1;
        hold_idx   = VIDX_W'(v);
      end
      if (!free_found && !act_q[v]) begin
        free_found = 1'b1;
        free_idx   = VIDX_W'(v);
      end
      if (!rel_found && act_q[v] && !sus_q[v] && note_q[v] == p_q) begin
        rel_found = 1'b1;
        rel_idx   = VIDX_W'(v);
      end
    end
  end

`ifdef HARP_VOICE_STEAL_EN
  logic [VIDX_W-1:0] steal_idx, best_age;

  // Strict compare keeps the lowest index on age ties.
  always_comb begin
    steal_idx = '0;
    best_age  = age_q[0];
    for (int unsigned v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > best_age) begin
        best_age  = age_q[v];
        steal_idx = VIDX_W'(v);
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    pend_d     = pend_q;
    ptype_d    = ptype_q;
    pedal_up_d = pedal_up_q;
    drain_d    = drain_q;
    act_d      = act_q;
    sus_d      = sus_q;
    note_d     = note_q;
    age_d      = age_q;
    evt_d      = evt_q;
    drop_d     = drop_q;
    alloc_en   = 1'b0;
    alloc_idx  = '0;

    unique case (state_q)
      SCAN: begin
        if (pedal_up_q) begin
          state_d = DRAIN;
        end else begin
          p_d = p_q + NOTE_W'(1);
          if (pend_q[p_q]) begin
            pend_d[p_q] = 1'b0;
            if (ptype_q[p_q]) begin
              if (hold_found) begin
                alloc_en  = 1'b1;
                alloc_idx = hold_idx;
              end else if (free_found) begin
                alloc_en  = 1'b1;
                alloc_idx = free_idx;
              end else begin
`ifdef HARP_VOICE_STEAL_EN
                alloc_en  = 1'b1;
                alloc_idx = steal_idx;
`else
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
`endif
              end
            end else if (rel_found) begin
              if (pedal_lvl) begin
                sus_d[rel_idx] = 1'b1;
              end else begin
                act_d[rel_idx] = 1'b0;
                evt_d.on       = 1'b0;
                evt_d.voice    = VOICE_W'(rel_idx);
                evt_d.note     = p_q;
                state_d        = EMIT;
              end
            end
          end
        end
      end
      EMIT: begin
        if (evt_ready) state_d = pedal_up_q ? DRAIN : SCAN;
      end
      DRAIN: begin
        if (act_q[drain_q] && sus_q[drain_q]) begin
          act_d[drain_q] = 1'b0;
          sus_d[drain_q] = 1'b0;
          evt_d.on       = 1'b0;
          evt_d.voice    = VOICE_W'(drain_q);
          evt_d.note     = note_q[drain_q];
          state_d        = EMIT;
        end
        if (drain_q == LAST_IDX) begin
          drain_d    = '0;
          pedal_up_d = 1'b0;
          if (state_d == DRAIN) state_d = SCAN;
        end else begin
          drain_d = drain_q + VIDX_W'(1);
        end
      end
      default: state_d = SCAN;
    endcase

    if (alloc_en) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (VIDX_W'(v) == alloc_idx) begin
          act_d[v]  = 1'b1;
          sus_d[v]  = 1'b0;
          note_d[v] = p_q;
          age_d[v]  = '0;
        end else if (act_q[v] && age_q[v] != AGE_MAX) begin
          age_d[v] = age_q[v] + VIDX_W'(1);
        end
      end
      evt_d.on    = 1'b1;
      evt_d.voice = VOICE_W'(alloc_idx);
      evt_d.note  = p_q;
      state_d     = EMIT;
    end

    // A fresh debounced flip overrides any service of the same beam this cycle.
    for (int unsigned b = 0; b < NUM_BEAMS; b++) begin
      if (beam_flip[b]) begin
        pend_d[b]  = 1'b1;
        ptype_d[b] = beam_lvl[b];
      end
    end
    if (pedal_flip && !pedal_lvl) pedal_up_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SCAN;
      p_q        <= '0;
      pend_q     <= '0;
      ptype_q    <= '0;
      pedal_up_q <= 1'b0;
      drain_q    <= '0;
      act_q      <= '0;
      sus_q      <= '0;
      evt_q      <= '0;
      drop_q     <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      pend_q     <= pend_d;
      ptype_q    <= ptype_d;
      pedal_up_q <= pedal_up_d;
      drain_q    <= drain_d;
      act_q      <= act_d;
      sus_q      <= sus_d;
      evt_q      <= evt_d;
      drop_q     <= drop_d;
      note_q     <= note_d;
      age_q      <= age_d;
    end
  end

  always_comb begin
    voice_note = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      voice_note[NOTE_W*v +: NOTE_W] = note_q[v];
    end
  end

  assign voice_active = act_q;
  assign evt_valid    = (state_q == EMIT);
  assign evt_data     = {evt_q.on, VIDX_W'(evt_q.voice), evt_q.note};
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_harp_voice_allocator.sv
// Randomized scoreboard bench: a voice-pool model predicts note events, a monitor checks them.
module tb_harp_voice_allocator;

  localparam int NV  = 4;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    beam = '0;
  logic          pedal = 1'b0;
  logic          evt_ready = 1'b0;
  logic [NV-1:0] voice_active;
  logic [3*NV-1:0] voice_note;
  logic          evt_valid;
  logic [5:0]    evt_data;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  harp_voice_allocator #(.NUM_VOICES(NV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .beam        (beam),
    .pedal       (pedal),
    .voice_active(voice_active),
    .voice_note  (voice_note),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_data    (evt_data),
    .drop_count  (drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit stall    = 1'b1;

  typedef struct {
    logic [5:0]    data;
    logic [NV-1:0] act;
    int            grp;
  } exp_t;
  exp_t exp_q[$];

  // Model: voice pool with allocation timestamps; LRU age derived from them.
  bit m_act[NV];
  bit m_sus[NV];
  int m_note[NV];
  int m_ts[NV];
  int m_allocs;
  int m_drop;
  bit m_pedal;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [NV-1:0] m_pack();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = m_act[v];
    return r;
  endfunction

  function automatic int m_age(int v);
    int a;
    a = m_allocs - m_ts[v];
    return (a > NV - 1) ? NV - 1 : a;
  endfunction

  task automatic m_reset();
    for (int v = 0; v < NV; v++) begin
      m_act[v] = 0; m_sus[v] = 0; m_note[v] = 0; m_ts[v] = 0;
    end
    m_allocs = 0; m_drop = 0; m_pedal = 0;
    exp_q.delete();
  endtask

  task automatic push(bit on, int v, int n, int grp);
    exp_t e;
    e.data = {on, 2'(v), 3'(n)};
    e.act  = m_pack();
    e.grp  = grp;
    exp_q.push_back(e);
  endtask

  task automatic m_alloc(int v, int n);
    m_act[v] = 1; m_sus[v] = 0; m_note[v] = n;
    m_allocs++;
    m_ts[v] = m_allocs;
    push(1, v, n, 0);
  endtask

  task automatic m_press(int n);
    int best;
    for (int v = 0; v < NV; v++)
      if (m_act[v] && m_sus[v] && m_note[v] == n) begin m_alloc(v, n); return; end
    for (int v = 0; v < NV; v++)
      if (!m_act[v]) begin m_alloc(v, n); return; end
`ifdef HARP_VOICE_STEAL_EN
    best = 0;
    for (int v = 1; v < NV; v++) if (m_age(v) > m_age(best)) best = v;
    m_alloc(best, n);
`else
    best = 0;
    if (m_drop != 65535) m_drop = m_drop + 1 + best;
`endif
  endtask

  task automatic m_release(int n, int grp);
    for (int v = 0; v < NV; v++)
      if (m_act[v] && !m_sus[v] && m_note[v] == n) begin
        if (m_pedal) m_sus[v] = 1;
        else begin m_act[v] = 0; push(0, v, n, grp); end
        return;
      end
  endtask

  task automatic m_pedal_up();
    m_pedal = 0;
    for (int v = 0; v < NV; v++)
      if (m_act[v] && m_sus[v]) begin
        m_act[v] = 0; m_sus[v] = 0;
        push(0, v, m_note[v], 0);
      end
  endtask

  // Monitor: drives ready, checks hold-while-stalled and pops the scoreboard on handshakes.
  initial begin
    logic [5:0] prev_data;
    bit         prev_wait;
    exp_t       e;
    int         k;
    prev_wait = 0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (prev_wait && reset_n) chk("evt_hold", {25'd0, evt_valid, evt_data}, {25'd0, 1'b1, prev_data});
      evt_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (evt_valid && evt_ready && reset_n) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL evt_unexpected: got %0h, expected no event (t=%0t)", evt_data, $time);
        end else begin
          k = 0;
          if (evt_data !== exp_q[0].data && exp_q.size() > 1 && exp_q[0].grp != 0 &&
              exp_q[1].grp == exp_q[0].grp) k = 1;
          e = exp_q[k];
          exp_q.delete(k);
          chk("evt_data", evt_data, e.data);
          if (e.grp == 0) chk("evt_active", voice_active, e.act);
        end
      end
      prev_wait = evt_valid && !evt_ready && reset_n;
      prev_data = evt_data;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    int t;
    tick(24);
    t = 0;
    while ((exp_q.size() != 0 || evt_valid) && t < 400) begin
      tick(1);
      t++;
    end
    if (t >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL settle_timeout: got %0d events outstanding, expected 0", exp_q.size());
    end
    chk("voice_active", voice_active, m_pack());
    chk("drop_count", drop_count, m_drop);
    for (int v = 0; v < NV; v++)
      if (m_act[v]) chk("voice_note", voice_note[3*v +: 3], m_note[v]);
  endtask

  task automatic toggle_beam(int b);
    @(negedge clk);
    beam[b] = ~beam[b];
    if (beam[b]) m_press(b);
    else m_release(b, 0);
    settle();
  endtask

  task automatic toggle_pedal();
    @(negedge clk);
    pedal = ~pedal;
    if (pedal) m_pedal = 1;
    else m_pedal_up();
    settle();
  endtask

  task automatic glitch(int b, int len);
    @(negedge clk);
    beam[b] = ~beam[b];
    tick(len);
    beam[b] = ~beam[b];
    settle();
  endtask

  task automatic release_all();
    for (int b = 0; b < 8; b++) if (beam[b]) toggle_beam(b);
  endtask

  initial begin
    int r;
    int t;
    m_reset();
    tick(3);
    chk("reset_active", voice_active, 0);
    chk("reset_valid", evt_valid, 0);
    chk("reset_data", evt_data, 0);
    chk("reset_note", voice_note, 0);
    chk("reset_drop", drop_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    stall   = 1'b0;

    glitch(3, 3);
    toggle_beam(3);
    chk("first_press_active", voice_active, 4'b0001);
    toggle_beam(3);

    for (int b = 0; b < 5; b++) toggle_beam(b);
`ifdef HARP_VOICE_STEAL_EN
    chk("steal_note", voice_note[2:0], 4);
`else
    chk("drop_one", drop_count, 1);
`endif

    toggle_pedal();
    toggle_beam(2);
    chk("sustain_keeps_voice", voice_active[2], 1);
    toggle_beam(1);
    toggle_pedal();
    release_all();

    // Two presses queued behind a stalled consumer.
    stall = 1'b1;
    @(negedge clk);
    beam[5] = 1'b1;
    m_press(5);
    tick(10);
    beam[7] = 1'b1;
    m_press(7);
    tick(25);
    stall = 1'b0;
    settle();
    release_all();

    // Simultaneous releases: order follows the scan pointer, so either is accepted.
    toggle_beam(1);
    toggle_beam(6);
    @(negedge clk);
    beam[1] = 1'b0;
    beam[6] = 1'b0;
    m_release(1, 1);
    m_release(6, 1);
    settle();

    repeat (80) begin
      r = $urandom_range(0, 9);
      if (r < 7) toggle_beam($urandom_range(0, 7));
      else if (r < 8) toggle_pedal();
      else glitch($urandom_range(0, 7), $urandom_range(1, 3));
    end
    release_all();
    if (pedal) toggle_pedal();

    // Reset while an event is being presented.
    stall = 1'b1;
    @(negedge clk);
    beam[0] = 1'b1;
    m_press(0);
    t = 0;
    while (!evt_valid && t < 40) begin
      tick(1);
      t++;
    end
    chk("valid_before_reset", evt_valid, 1);
    @(negedge clk);
    reset_n = 1'b0;
    beam    = '0;
    pedal   = 1'b0;
    #1;
    chk("midreset_valid", evt_valid, 0);
    chk("midreset_active", voice_active, 0);
    chk("midreset_drop", drop_count, 0);
    m_reset();
    tick(3);
    stall   = 1'b0;
    reset_n = 1'b1;
    tick(40);
    chk("post_reset_valid", evt_valid, 0);
    chk("post_reset_active", voice_active, 0);
    toggle_beam(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/harp_voice_allocator.md
# harp_voice_allocator

Scheduler between the eight photodiode beams plus sustain pedal and a fixed pool of synthesizer voices. It synchronizes and debounces each beam and the pedal. It services beam edges round-robin, assigns a voice to each broken beam and frees voices on release or pedal-up. Every allocation change is reported to the HPS/audio side as a note event over a valid/ready handshake.

## Interface
- NUM_VOICES, 4: voices in pool (2..8); VIDX_W = $clog2(NUM_VOICES)
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles before a beam or pedal change is accepted (1 ms at 50 MHz)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- beam  in  8  raw photodiode inputs; 1 = beam broken; asynchronous
- pedal  in  1  raw sustain pedal; 1 = pressed; asynchronous
- voice_active  out  NUM_VOICES  voice gate, 1 = sounding or sustained
- voice_note  out  3*NUM_VOICES  beam index per voice, voice v at [3v+2:3v]
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event when high with evt_valid
- evt_data  out  4+VIDX_W  {on(1), voice(VIDX_W), note(3)}; on=1 note-on, 0 note-off
- drop_count  out  16  note-ons discarded for lack of a voice; saturating

## Operation
- Each beam and the pedal pass through a 2-flop synchronizer and then a debouncer. The debounced state flips after DEBOUNCE_CYCLES consecutive cycles of the opposite value. A flip sets that beam's pending flag, type press or release. A newer flip overwrites the older one.
- Per voice: active, sustained, note[2:0], age[VIDX_W-1:0] (LRU rank, 0 = newest).
- FSM states:
  - SCAN: scan pointer p (0..7) advances one beam per cycle and wraps 7->0. If pending[p] is set, the event is serviced, pending[p] is cleared and the FSM goes to EMIT when an event results. p holds while not in SCAN.
  - EMIT: evt_valid=1 and evt_data stable until evt_ready. Then the FSM returns to SCAN, or to DRAIN if the pedal-up flag is set.
  - DRAIN: one cycle per voice in ascending index. Each sustained voice is freed and emits a note-off via EMIT. After the last voice the pedal-up flag clears and the FSM returns to SCAN.
- Press on beam n:
  - If a voice already holds n (sustained), it is reused: sustained cleared, age 0, note-on emitted.
  - Otherwise the lowest-index inactive voice is allocated.
  - If none is free, handling follows the Configuration section.
- Release on beam n: find the active, non-sustained voice with note n.
  - Pedal debounced high: set sustained, no event.
  - Pedal low: free the voice and emit a note-off.
  - No matching voice: no event.
- Allocation sets the new voice's age to 0 and increments every other active voice's age, saturating at NUM_VOICES-1.
- Pedal debounced falling edge sets the pedal-up flag. DRAIN is entered from SCAN on the next cycle and has priority over the pending beam at p.

## Timing
- Reset values:
  - all outputs 0, drop_count 0, evt_valid 0
  - debounced beams 0, debounced pedal 0, pending flags 0
  - FSM in SCAN, p = 0
- A beam broken across reset produces a press after 2 + DEBOUNCE_CYCLES cycles.
- Latency from raw edge to evt_valid: 2 sync + DEBOUNCE_CYCLES + up to 8 scan cycles + 1 register.
- voice_active and voice_note update in the same cycle evt_valid rises.
- evt_data must not change while evt_valid=1 and evt_ready=0.
- Asserting reset mid-operation clears everything immediately, with no trailing events.

## Configuration
- HARP_VOICE_STEAL_EN defined: a press with no free voice steals the active voice with the highest age (ties: lowest index). One note-on is emitted for the stolen voice with the new note. No separate note-off is emitted. drop_count is unchanged.
- Undefined: the press is discarded, pending is cleared, no event is emitted, and drop_count increments, saturating at 16'hFFFF.

## Structure
- Package harp_pkg holds:
  - NUM_BEAMS = 8, NOTE_W = 3
  - FSM state enum {SCAN, EMIT, DRAIN}
  - packed event struct {on, voice, note}
- Sub-module harp_debounce: synchronizer plus counter, parameter DEBOUNCE_CYCLES. Outputs the debounced level and a one-cycle rise/fall strobe. Instantiated 9 times.

## Test plan
- DEBOUNCE_CYCLES=4: break beam 3 for 3 cycles then restore -> no event; hold it for 10 cycles -> evt_data={1,0,3}, voice_active=4'b0001.
- Break beams 0,1,2,3,4 in sequence, NUM_VOICES=4:
  - with HARP_VOICE_STEAL_EN -> 5th event {1,0,4}, voice_note[2:0]=4
  - without it -> no 5th event, drop_count=1
- Pedal held, release beam 2 -> no event, voice stays active. Pedal up -> note-off {0,v,2} per sustained voice in ascending voice order.
- Hold evt_ready=0 for 20 cycles with two pending presses -> evt_data constant. After ready, the second event follows and none is lost.
- Beams 1 and 6 debounce in the same cycle -> events emitted in scan order from the current p, both delivered.
- Assert reset_n low while evt_valid=1 -> all outputs 0 on the next edge, no event after reset release until a new debounced edge.
